// File: rtl/fifo_pkg.sv
// Shared types, constants and the credit helper for the FIFO packet drain.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } drain_state_t;

    localparam int SKID_DEPTH = 2;

    // A new pop is safe if the skid still has room once the departing beat
    // and the word already in flight from the FIFO are accounted for.
    function automatic logic has_credit(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       leaving
    );
        logic [2:0] net;
        net = {1'b0, occ} + {2'b00, inflight} - {2'b00, leaving};
        return (net < 3'(SKID_DEPTH));
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order holding buffer; entry 0 is always the oldest word.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       occ_q;

    // Storage update: shift on pop, fill the first free slot on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_q <= data_i;
                    end else begin
                        ent1_q <= data_i;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= data_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= data_i;
                    end
                end
                default: begin
                    occ_q <= occ_q;
                end
            endcase
        end
    end

    assign data_o = ent0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_pkt_drain.sv
// Pops a synchronous FIFO, hides its read latency and emits fixed-length
// valid/ready packets with a last-beat marker and a completed-packet count.
module fifo_pkt_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    drain_state_t     state_q;
    logic             inflight_q;
    logic [BW-1:0]    fetch_cnt_q;
    logic [BW-1:0]    beat_cnt_q;
    logic [CNT_W-1:0] pkt_count_q;
    logic [1:0]       occ_s;
    logic             allow_s;
    logic             pop_s;
    logic             xfer_s;

    stream_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .data_i (fifo_dout),
        .pop_i  (xfer_s),
        .data_o (m_data),
        .occ_o  (occ_s)
    );

    assign m_valid = (occ_s != 2'd0);
    assign m_last  = m_valid && (beat_cnt_q == LAST_BEAT);
    assign xfer_s  = m_valid && m_ready;
    assign pop_s   = fifo_rd_en && !fifo_empty;

    // Pop permission per state plus the skid credit check.
    always_comb begin
        allow_s = 1'b0;
        case (state_q)
            IDLE:    allow_s = 1'b0;
            RUN:     allow_s = 1'b1;
            FINISH:  allow_s = (fetch_cnt_q != '0);
            default: allow_s = 1'b0;
        endcase
        if (allow_s && !fifo_empty) begin
            fifo_rd_en = has_credit(occ_s, inflight_q, xfer_s);
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    // Control FSM together with the pop, beat and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inflight_q  <= 1'b0;
            fetch_cnt_q <= '0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q <= pop_s;
            if (pop_s) begin
                fetch_cnt_q <= (fetch_cnt_q == LAST_BEAT) ? '0 : fetch_cnt_q + BW'(1);
            end
            if (xfer_s) begin
                beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BW'(1);
                if (m_last) begin
                    pkt_count_q <= pkt_count_q + CNT_W'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    if (!en) state_q <= FINISH;
                end
                FINISH: begin
                    if (en) begin
                        state_q <= RUN;
                    end else if ((fetch_cnt_q == '0) && (occ_s == 2'd0) &&
                                 !inflight_q && (beat_cnt_q == '0)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;

endmodule
